keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SETTLE_CYCLES, default 1000, clock cycles each column is driven before its rows are sampled (minimum 2).
REQ-002 DEBOUNCE_SCANS, default 4, consecutive identical full-scan results needed to accept a change (minimum 2).
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col  output  4  keypad column drives, active-low, exactly one bit low at any time.
REQ-006 row  input  4  keypad row returns, active-low; external pull-ups; asynchronous to clock.
REQ-007 keypadButton  output  4  hex code of the last accepted key press.
REQ-008 key_valid  output  1  one-cycle pulse when a new press is accepted.
REQ-009 key_held  output  1  level; high while the accepted key remains debounced-pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 Scan phases col0..col3 in order, col = 1110, 1101, 1011, 0111, wrapping col3 -> col0.
REQ-012 Each phase SHALL last exactly SETTLE_CYCLES cycles; a full scan is 4*SETTLE_CYCLES cycles.
REQ-013 Synchronized rows SHALL be sampled on the last cycle of each phase.
REQ-014 Key map (col,row) -> code: col0: rows 0..3 = 1,4,7,0; col1: 2,5,8,F; col2: 3,6,9,E; col3: A,B,C,D.
REQ-015 At the end of each scan the scan result SHALL be: NONE if no row was low in any phase; KEY(code) if exactly one key was detected; NONE if two or more keys were detected (multi-key rejection).
REQ-016 Debounce: if the scan result equals the previous scan result, the stable counter increments, saturating at DEBOUNCE_SCANS; otherwise it loads 1.
REQ-017 When the stable counter reaches DEBOUNCE_SCANS with result KEY(c) and key_held = 0: keypadButton <= c, key_held <= 1, key_valid high for exactly the next cycle.
REQ-018 When the stable counter reaches DEBOUNCE_SCANS with result NONE: key_held <= 0; keypadButton keeps its value; no pulse.
REQ-019 While key_held = 1, a stable KEY(c') with c' != c SHALL be ignored (no pulse) until a stable NONE is reached (release required between presses).
REQ-020 key_valid SHALL never be high on two consecutive cycles and SHALL pulse at most once per press.
REQ-021 Scanning SHALL run continuously, independent of output state.

Reset
REQ-022 While reset is high: col = 1110, phase counter = 0, phase = col0, stable counter = 0, previous result = NONE, partial scan data cleared, keypadButton = 0, key_valid = 0, key_held = 0, synchronizer flops = 1111.
REQ-023 The first cycle after reset deasserts SHALL begin phase col0 cycle 0.
REQ-024 Reset asserted mid-scan or mid-debounce SHALL discard all progress; a held key must then pass full debounce again.

Verification (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3; scan = 16 cycles)
REQ-025 Reset, rows = 1111 -> col 1110 for cycles 0-3, 1101 for 4-7, 1011 for 8-11, 0111 for 12-15, 1110 at 16; all outputs 0 throughout.
REQ-026 Key 5 (col1,row1) held from reset release -> exactly one key_valid pulse right after scan 3 completes, keypadButton = 5, key_held = 1; no further pulse over 10 more scans.
REQ-027 Key 5 pressed for 2 scans, released for 1, pressed for 2, released -> no key_valid, key_held stays 0.
REQ-028 Keys 1 and 2 held together for 5 scans -> no pulse; then 1 released, 2 kept -> pulse after 3 more scans, keypadButton = 2.
REQ-029 After REQ-026, release key -> key_held falls after 3 empty scans, keypadButton stays 5; press key D -> pulse, keypadButton = D.
REQ-030 Key 9 held, reset pulsed mid-scan 2 -> outputs 0, col = 1110 next cycle; pulse only after 3 full scans counted from reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, builds a
//   per-scan result (no key / one key / several keys), debounces that result
//   across consecutive scans and reports accepted presses.
//
//   Ports
//     clock         system clock, everything on the rising edge
//     reset         synchronous, active-high
//     col[3:0]      column drives, active-low, exactly one low at a time
//     row[3:0]      row returns, active-low, asynchronous to clock
//     keypadButton  hex code of the last accepted key
//     key_valid     one-cycle pulse on each accepted press
//     key_held      high while the accepted key stays debounced-pressed
//
//   Scan phase FSM
//     state    | meaning
//     PH_COL0  | col = 1110, keys 1 4 7 0
//     PH_COL1  | col = 1101, keys 2 5 8 F
//     PH_COL2  | col = 1011, keys 3 6 9 E
//     PH_COL3  | col = 0111, keys A B C D; scan result evaluated on its last cycle
//
//   The sampled rows trail the column drive by the two synchronizer stages,
//   so SETTLE_CYCLES should comfortably exceed 2 for clean column attribution.

module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] keypadButton,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        PH_COL0 = 2'd0,
        PH_COL1 = 2'd1,
        PH_COL2 = 2'd2,
        PH_COL3 = 2'd3
    } phase_t;

    phase_t          phase;
    phase_t          phase_next;
    logic [PW-1:0]   phase_cnt;
    logic            phase_end;
    logic            scan_end;

    logic [3:0]      row_meta;
    logic [3:0]      row_sync;

    logic [3:0]      rows_low;
    logic [2:0]      n_hits;
    logic [1:0]      row_idx;
    logic [3:0]      phase_code;

    // acc_count: 0 = nothing seen yet this scan, 1 = one key, 2 = two or more
    logic [1:0]      acc_count;
    logic [3:0]      acc_code;
    logic [2:0]      total_hits;
    logic [1:0]      merged_count;
    logic [3:0]      merged_code;

    logic            res_key;
    logic [3:0]      res_code;
    logic            prev_key;
    logic [3:0]      prev_code;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_next;

    function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        case ({c, r})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer (idle keypad reads all ones)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Phase timing
    // ------------------------------------------------------------------
    assign phase_end = (phase_cnt == PHASE_LAST);
    assign scan_end  = phase_end && (phase == PH_COL3);

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (phase_end) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= PH_COL0;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        col        = 4'b1110;
        case (phase)
            PH_COL0: begin
                col = 4'b1110;
                if (phase_end) phase_next = PH_COL1;
            end
            PH_COL1: begin
                col = 4'b1101;
                if (phase_end) phase_next = PH_COL2;
            end
            PH_COL2: begin
                col = 4'b1011;
                if (phase_end) phase_next = PH_COL3;
            end
            PH_COL3: begin
                col = 4'b0111;
                if (phase_end) phase_next = PH_COL0;
            end
            default: begin
                col        = 4'b1110;
                phase_next = PH_COL0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-phase row decode and scan accumulation
    // ------------------------------------------------------------------
    assign rows_low = ~row_sync;
    assign n_hits   = {2'b00, rows_low[0]} + {2'b00, rows_low[1]}
                    + {2'b00, rows_low[2]} + {2'b00, rows_low[3]};

    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows_low[i]) row_idx = 2'(i);
        end
    end

    assign phase_code = key_code(phase, row_idx);

    // Merge this phase's sample with what earlier phases of the scan found.
    // Only when the merged count is exactly one does the code matter, and
    // then it comes from whichever source contributed the single hit.
    always_comb begin
        total_hits   = {1'b0, acc_count} + n_hits;
        merged_count = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
        merged_code  = (n_hits != 3'd0) ? phase_code : acc_code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_count <= 2'd0;
            acc_code  <= 4'h0;
        end else if (scan_end) begin
            acc_count <= 2'd0;
            acc_code  <= 4'h0;
        end else if (phase_end) begin
            acc_count <= merged_count;
            acc_code  <= merged_code;
        end
    end

    // Scan result, valid on the scan_end cycle. NONE carries code 0 so that
    // result comparison is a plain equality on {key, code}.
    assign res_key  = (merged_count == 2'd1);
    assign res_code = res_key ? merged_code : 4'h0;

    // ------------------------------------------------------------------
    // Debounce and output
    // ------------------------------------------------------------------
    always_comb begin
        if ({res_key, res_code} == {prev_key, prev_code}) begin
            stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 1'b1;
        end else begin
            stable_next = SW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_key     <= 1'b0;
            prev_code    <= 4'h0;
            stable_cnt   <= '0;
            keypadButton <= 4'h0;
            key_valid    <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                prev_key   <= res_key;
                prev_code  <= res_code;
                stable_cnt <= stable_next;
                if (stable_next == STABLE_MAX) begin
                    if (res_key) begin
                        // A different key appearing while one is held is
                        // ignored until a stable release clears key_held.
                        if (!key_held) begin
                            keypadButton <= res_code;
                            key_held     <= 1'b1;
                            key_valid    <= 1'b1;
                        end
                    end else begin
                        key_held <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
